// File: rtl/rf_alu_pkg.sv
// Shared definitions for the pipelined register-file + ALU execute core:
// opcode encoding, flag register layout and an opcode classifier.
package rf_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_ADC   = 3'd1,
    OP_SUB   = 3'd2,
    OP_SBB   = 3'd3,
    OP_AND   = 3'd4,
    OP_OR    = 3'd5,
    OP_XOR   = 3'd6,
    OP_PASSB = 3'd7
  } op_e;

  // Flag register, MSB first: zero, negative, carry, overflow.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  // Arithmetic ops update all four flags; logic ops only touch Z and N.
  function automatic logic op_is_arith(op_e op);
    return (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB) || (op == OP_SBB);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU. Arithmetic is done DATA_W+1 bits wide so the
// carry-out falls out of the top bit; subtraction is A + ~B + carry-in.
module alu_core
  import rf_alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              n,
  output logic              c,
  output logic              v
);

  op_e               op_i;
  logic              is_sub;
  logic              carry_in;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;

  assign op_i = op_e'(op);

  // Adder with operand inversion for subtraction, then result select.
  always_comb begin
    is_sub = (op_i == OP_SUB) || (op_i == OP_SBB);
    b_eff  = is_sub ? ~b : b;
    case (op_i)
      OP_ADC, OP_SBB: carry_in = cin;
      OP_SUB:         carry_in = 1'b1;
      default:        carry_in = 1'b0;
    endcase
    sum = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, carry_in};
    case (op_i)
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_PASSB: result = b;
      default:  result = sum[DATA_W-1:0];
    endcase
    z = (result == '0);
    n = result[DATA_W-1];
    // For subtraction C=1 means no borrow.
    c = sum[DATA_W];
    // Overflow: both adder inputs share a sign that the sum does not.
    v = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
  end

endmodule

// File: rtl/rf_alu_pipe.sv
// Two-stage execute core: operand read (with EX-result bypass) in the issue
// cycle, then ALU execute and register/flag write-back on the following edge.
// One operation per cycle, no stalls; ADC/SBB chain through the flag register.
module rf_alu_pipe
  import rf_alu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int REG_AW   = 3,
  parameter int IMM_W    = 5,
  parameter int IMM_SEXT = 0,
  parameter int R0_ZERO  = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [2:0]        op,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rd,
  input  logic              we,
  input  logic              src_b,
  input  logic [IMM_W-1:0]  imm,
  input  logic              flag_en,
  output logic [DATA_W-1:0] y,
  output logic              out_valid,
  output logic [REG_AW-1:0] out_rd,
  output logic              Z,
  output logic              N,
  output logic              C,
  output logic              V
);

  localparam int NUM_REGS = 2 ** REG_AW;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];

  logic              ex_valid_q, ex_valid_d;
  logic [2:0]        ex_op_q, ex_op_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
  logic              ex_we_q, ex_we_d;
  logic              ex_flag_en_q, ex_flag_en_d;

  logic [DATA_W-1:0] y_q, y_d;
  logic              out_valid_q, out_valid_d;
  logic [REG_AW-1:0] out_rd_q, out_rd_d;
  flags_t            flags_q, flags_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_z, alu_n, alu_c, alu_v;
  logic [DATA_W-1:0] imm_ext, a_rd, b_rd;
  logic              a_zero, b_zero, a_hit, b_hit;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .a      (ex_a_q),
    .b      (ex_b_q),
    .cin    (flags_q.c),
    .op     (ex_op_q),
    .result (alu_result),
    .z      (alu_z),
    .n      (alu_n),
    .c      (alu_c),
    .v      (alu_v)
  );

  // Operand read: forced-zero r0, bypass from the EX result, else the RF.
  always_comb begin
    if (IMM_SEXT != 0) imm_ext = DATA_W'($signed(imm));
    else               imm_ext = DATA_W'(imm);
    a_zero = (R0_ZERO != 0) && (ra == '0);
    b_zero = (R0_ZERO != 0) && (rb == '0);
    a_hit  = ex_valid_q && ex_we_q && (ex_rd_q == ra);
    b_hit  = ex_valid_q && ex_we_q && (ex_rd_q == rb);
    if (a_zero)     a_rd = '0;
    else if (a_hit) a_rd = alu_result;
    else            a_rd = rf_q[ra];
    if (src_b)      b_rd = imm_ext;
    else if (b_zero) b_rd = '0;
    else if (b_hit) b_rd = alu_result;
    else            b_rd = rf_q[rb];
  end

  // Issue: capture the operation into EX when one is presented.
  always_comb begin
    ex_valid_d   = in_valid;
    ex_op_d      = ex_op_q;
    ex_a_d       = ex_a_q;
    ex_b_d       = ex_b_q;
    ex_rd_d      = ex_rd_q;
    ex_we_d      = ex_we_q;
    ex_flag_en_d = ex_flag_en_q;
    if (in_valid) begin
      ex_op_d      = op;
      ex_a_d       = a_rd;
      ex_b_d       = b_rd;
      ex_rd_d      = rd;
      ex_we_d      = we;
      ex_flag_en_d = flag_en;
    end
  end

  // Execute/write-back: result register, RF write and flag update.
  always_comb begin
    rf_d        = rf_q;
    y_d         = y_q;
    out_rd_d    = out_rd_q;
    out_valid_d = ex_valid_q;
    flags_d     = flags_q;
    if (ex_valid_q) begin
      y_d      = alu_result;
      out_rd_d = ex_rd_q;
      if (ex_we_q && !((R0_ZERO != 0) && (ex_rd_q == '0))) rf_d[ex_rd_q] = alu_result;
      if (ex_flag_en_q) begin
        flags_d.z = alu_z;
        flags_d.n = alu_n;
        if (op_is_arith(op_e'(ex_op_q))) begin
          flags_d.c = alu_c;
          flags_d.v = alu_v;
        end
      end
    end
  end

  // State registers; reset clears everything including in-flight work.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      ex_valid_q   <= 1'b0;
      ex_op_q      <= '0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_rd_q      <= '0;
      ex_we_q      <= 1'b0;
      ex_flag_en_q <= 1'b0;
      y_q          <= '0;
      out_valid_q  <= 1'b0;
      out_rd_q     <= '0;
      flags_q      <= '0;
    end else begin
      rf_q         <= rf_d;
      ex_valid_q   <= ex_valid_d;
      ex_op_q      <= ex_op_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_rd_q      <= ex_rd_d;
      ex_we_q      <= ex_we_d;
      ex_flag_en_q <= ex_flag_en_d;
      y_q          <= y_d;
      out_valid_q  <= out_valid_d;
      out_rd_q     <= out_rd_d;
      flags_q      <= flags_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;
  assign out_rd    = out_rd_q;
  assign Z         = flags_q.z;
  assign N         = flags_q.n;
  assign C         = flags_q.c;
  assign V         = flags_q.v;

endmodule

// File: doc/rf_alu_pipe.md
Name: rf_alu_pipe

Overview:
Parametrised successor of the 16-bit register-file-plus-ALU datapath. Adds a two-stage pipeline (operand read, then execute/write-back), an internal flag register that feeds ADC/SBB carry chaining in place of the external carry input, a wider opcode set, and a result bypass so back-to-back dependent operations issue without stalls. It is the execute core of the next single-issue RISC datapath; the decoder drives it one operation per cycle.

Parameters:
DATA_W, 16, datapath and register width
REG_AW, 3, register address width (NUM_REGS = 2**REG_AW)
IMM_W, 5, immediate field width (IMM_W <= DATA_W)
IMM_SEXT, 0, 1 = sign-extend immediate, 0 = zero-extend
R0_ZERO, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
clk  in  1  clock, rising edge
clr  in  1  asynchronous reset, active low
in_valid  in  1  operation present this cycle
op  in  3  opcode: ADD, ADC, SUB, SBB, AND, OR, XOR, PASSB
ra  in  REG_AW  source A register
rb  in  REG_AW  source B register
rd  in  REG_AW  destination register
we  in  1  write result to rd
src_b  in  1  0 = B from rb, 1 = extended immediate
imm  in  IMM_W  immediate
flag_en  in  1  update flags from this operation
y  out  DATA_W  registered result
out_valid  out  1  y/out_rd valid
out_rd  out  REG_AW  destination of y
Z, N, C, V  out  1 each  flag register

Behaviour:
- Reset (clr low, asynchronous): all registers, EX stage, y, out_valid, out_rd, and Z/N/C/V go to 0 immediately. Reset mid-operation discards in-flight operations. No RF write occurs while clr is low.
- Stage RD (combinational in the issue cycle): read ra and rb, and select B from rb or the extended immediate.
- Bypass: if the EX stage is valid with we=1 and its rd equals ra (or rb), use the EX ALU result instead of the RF value. With R0_ZERO=1, register 0 is never bypassed and reads 0.
- Issue edge T0: if in_valid, capture op, operands, rd, we, and flag_en into the EX register. EX valid = in_valid.
- Execute edge T1: the ALU evaluates during the T0..T1 cycle. At T1:
  - y <= result; out_rd <= rd; out_valid <= 1 (otherwise 0).
  - If we=1, RF[rd] <= result.
  - If flag_en=1, flags are updated.
- Latency is 2 edges from issue to y. Throughput is 1 operation per cycle with no stalls. An operation issued at T1 reads the value written at T1 through the bypass. An operation issued at T2 reads the RF directly.
- Arithmetic is DATA_W+1 bits wide:
  - ADD: A+B.
  - ADC: A+B+C.
  - SUB: A+~B+1.
  - SBB: A+~B+C.
  - C = carry-out, so for subtraction 1 means no borrow.
  - V = signed overflow, from operand and result MSBs.
  - Carry-in for ADC/SBB is the flag register. Back-to-back chained operations are exact because flags update at the producer's execute edge, before the consumer executes.
- Logic ops (AND, OR, XOR, PASSB = B): Z and N are updated; C and V are held.
- Z = (result == 0); N = result[DATA_W-1]. Wrap-around is modulo 2**DATA_W.
- flag_en=0: flags are held regardless of op. in_valid=0: no write, no flag change.
- Simultaneous RF write and external read of the same register: the bypass value wins.

Decomposition:
- Package rf_alu_pkg holds:
  - the op encoding: ADD=0, ADC=1, SUB=2, SBB=3, AND=4, OR=5, XOR=6, PASSB=7;
  - the flag struct/index constants.
- Sub-module alu_core: purely combinational A, B, cin, op -> result, Z, N, C, V. Pipeline, RF and bypass logic stay in the top module.

Test Plan:
- Reset then writes: clr low mid-stream -> outputs and flags 0 at once, EX contents discarded. Then ADD r1=r0+imm 5 -> y=5 at the second edge, out_rd=1.
- Back-to-back dependency: ADD r1=r0+imm 3, next cycle ADD r2=r1+imm 4 -> y=3 then y=7. The bypass is exercised; r2=7.
- 32-bit chain (DATA_W=16): r1=0xFFFF, r2=0x0001, r3=0x0001, r4=0. ADD r5=r1+r2 (flag_en) then ADC r6=r3+r4 -> r5=0x0000, C=1, Z=1; r6=0x0002.
- Subtract/borrow: r1=0x0003, r2=0x0005, SUB r3=r1-r2 -> y=0xFFFE, C=0, N=1, V=0. r1=0x8000, r2=1, SUB -> y=0x7FFF, V=1, C=1.
- Flag hold: logic op XOR r1=r1^r1 with flag_en=1 after C=1 -> Z=1, C still 1. ADD with flag_en=0 -> flags unchanged.
- Parameter sweep: DATA_W=32, REG_AW=4, IMM_SEXT=1, imm=5'b11111 -> B=0xFFFFFFFF. With R0_ZERO=1: write r0=9, then read r0 -> 0.
